// File: rtl/dmem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter_if
//
// Purpose: bundles every bus signal around the data-memory port arbiter.
// This covers the two requester ports, the shared downstream memory port and
// the status outputs.
//
// Signals:
//   p0_* / p1_*      requester ports: read/write request, word address,
//                    store data, load data, one-cycle done pulse
//   d_mem_*          downstream port: read/write strobes, address, write
//                    data, ready (accept), valid (read data), read data
//   timeout_err      sticky watchdog abort flag
//   grant_owner      current / last granted port
//
// Modports:
//   slave   the arbiter's view
//   master  the surrounding system's view (requesters plus memory)
// ----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    p0_read;
    logic                    p0_write;
    logic [ADDRESS_BITS-1:0] p0_address;
    logic [DATA_WIDTH-1:0]   p0_wdata;
    logic [DATA_WIDTH-1:0]   p0_rdata;
    logic                    p0_done;

    logic                    p1_read;
    logic                    p1_write;
    logic [ADDRESS_BITS-1:0] p1_address;
    logic [DATA_WIDTH-1:0]   p1_wdata;
    logic [DATA_WIDTH-1:0]   p1_rdata;
    logic                    p1_done;

    logic                    d_mem_read;
    logic                    d_mem_write;
    logic [ADDRESS_BITS-1:0] d_mem_address;
    logic [DATA_WIDTH-1:0]   d_mem_in_data;
    logic                    d_mem_ready;
    logic                    d_mem_valid;
    logic [DATA_WIDTH-1:0]   d_mem_out_data;

    logic                    timeout_err;
    logic                    grant_owner;

    modport slave (
        input  p0_read, p0_write, p0_address, p0_wdata,
        output p0_rdata, p0_done,
        input  p1_read, p1_write, p1_address, p1_wdata,
        output p1_rdata, p1_done,
        output d_mem_read, d_mem_write, d_mem_address, d_mem_in_data,
        input  d_mem_ready, d_mem_valid, d_mem_out_data,
        output timeout_err, grant_owner
    );

    modport master (
        output p0_read, p0_write, p0_address, p0_wdata,
        input  p0_rdata, p0_done,
        output p1_read, p1_write, p1_address, p1_wdata,
        input  p1_rdata, p1_done,
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_in_data,
        output d_mem_ready, d_mem_valid, d_mem_out_data,
        input  timeout_err, grant_owner
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose: shares one data-memory port between the core memory unit (port 0)
// and a secondary master such as a debug or DMA loader (port 1). Only one
// transaction is outstanding at a time. Ties are broken round-robin, and a
// watchdog aborts reads whose data never comes back.
//
// Ports:
//   clock   system clock; all state changes on the rising edge
//   reset   asynchronous, active-low reset
//   bus     dmem_port_arbiter_if.slave: both requester ports, the
//           downstream memory port, timeout_err and grant_owner
// ----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    dmem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                  state;
    state_t                  next_state;

    logic                    owner;
    logic                    last_grant;
    logic                    op_read;
    logic [ADDRESS_BITS-1:0] latched_address;
    logic [DATA_WIDTH-1:0]   latched_wdata;
    logic [15:0]             watchdog;
    logic [15:0]             watchdog_next;
    logic [DATA_WIDTH-1:0]   rdata0;
    logic [DATA_WIDTH-1:0]   rdata1;
    logic                    timeout_flag;

    logic                    pending0;
    logic                    pending1;
    logic                    take_grant;
    logic                    grant_port;
    logic                    capture_data;
    logic                    timeout_hit;

    assign pending0 = bus.p0_read | bus.p0_write;
    assign pending1 = bus.p1_read | bus.p1_write;

    always_comb begin
        next_state    = state;
        take_grant    = 1'b0;
        grant_port    = 1'b0;
        capture_data  = 1'b0;
        timeout_hit   = 1'b0;
        watchdog_next = watchdog;
        case (state)
            IDLE: begin
                if (pending0 | pending1) begin
                    take_grant = 1'b1;
                    // A tie goes to whichever port was not served last.
                    grant_port = (pending0 & pending1) ? ~last_grant : pending1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.d_mem_ready) begin
                    next_state = op_read ? WAIT : DONE;
                end
            end
            WAIT: begin
                watchdog_next = watchdog + 16'd1;
                // Data arriving on the last allowed cycle still wins over the abort.
                if (bus.d_mem_valid) begin
                    capture_data = 1'b1;
                    next_state   = DONE;
                end else if (watchdog_next == TIMEOUT_LIMIT) begin
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                watchdog_next = 16'd0;
                next_state    = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // last_grant starts at 1 so that port 0 wins the first tie after reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            op_read         <= 1'b0;
            latched_address <= '0;
            latched_wdata   <= '0;
            watchdog        <= 16'd0;
            rdata0          <= '0;
            rdata1          <= '0;
            timeout_flag    <= 1'b0;
        end else begin
            watchdog <= watchdog_next;
            // Read takes precedence when a port raises both read and write.
            if (take_grant) begin
                owner           <= grant_port;
                op_read         <= grant_port ? bus.p1_read : bus.p0_read;
                latched_address <= grant_port ? bus.p1_address : bus.p0_address;
                latched_wdata   <= grant_port ? bus.p1_wdata : bus.p0_wdata;
            end
            if (capture_data) begin
                if (owner) begin
                    rdata1 <= bus.d_mem_out_data;
                end else begin
                    rdata0 <= bus.d_mem_out_data;
                end
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
                if (owner) begin
                    rdata1 <= '0;
                end else begin
                    rdata0 <= '0;
                end
            end
            if (state == DONE) begin
                last_grant <= owner;
            end
        end
    end

    assign bus.d_mem_read    = (state == ISSUE) & op_read;
    assign bus.d_mem_write   = (state == ISSUE) & ~op_read;
    assign bus.d_mem_address = latched_address;
    assign bus.d_mem_in_data = latched_wdata;
    assign bus.p0_done       = (state == DONE) & ~owner;
    assign bus.p1_done       = (state == DONE) & owner;
    assign bus.p0_rdata      = rdata0;
    assign bus.p1_rdata      = rdata1;
    assign bus.timeout_err   = timeout_flag;
    assign bus.grant_owner   = owner;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one data memory interface between two requesters: port 0 is the core memory unit, port 1 is a secondary master (debug/DMA loader).
- Sits between the memory stage and the data cache/main memory.
- One transaction is outstanding at a time.
- Arbitration is round-robin, with a watchdog that aborts reads that never return.

Parameters:
DATA_WIDTH, 32, data bus width
ADDRESS_BITS, 20, word address width
TIMEOUT_CYCLES, 255, max cycles waiting for read response before abort (1..2^16-1)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
p0_read  input  1  port 0 read request, held until p0_done
p0_write  input  1  port 0 write request, held until p0_done
p0_address  input  ADDRESS_BITS  port 0 word address
p0_wdata  input  DATA_WIDTH  port 0 store data
p0_rdata  output  DATA_WIDTH  port 0 load data, valid with p0_done
p0_done  output  1  one-cycle completion pulse to port 0
p1_read, p1_write, p1_address, p1_wdata, p1_rdata, p1_done  same as port 0, for port 1
d_mem_read  output  1  downstream read strobe
d_mem_write  output  1  downstream write strobe
d_mem_address  output  ADDRESS_BITS  downstream address
d_mem_in_data  output  DATA_WIDTH  downstream write data
d_mem_ready  input  1  downstream can accept a request
d_mem_valid  input  1  downstream read data valid
d_mem_out_data  input  DATA_WIDTH  downstream read data
timeout_err  output  1  sticky error flag, set on watchdog abort
grant_owner  output  1  current/last granted port

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0, state IDLE, last_grant=1 (port 0 wins first tie), watchdog=0.
  - Reset mid-transaction drops the transaction: no done pulse, downstream strobes deassert immediately.
- A port request is pending when read|write is high. If both are high on one port, read takes precedence; write is ignored until a later request.
- States:
  - IDLE: if any request is pending, pick the owner, latch its address, wdata and op, set grant_owner, and go to ISSUE next cycle.
    - Only one pending: that port wins.
    - Both pending: the port not equal to last_grant wins.
  - ISSUE:
    - Drive d_mem_read or d_mem_write with the latched address/data; strobes are high for exactly one cycle of acceptance.
    - If d_mem_ready=1 that cycle, the request is accepted:
      - Write: pulse owner done next cycle and go to DONE.
      - Read: go to WAIT.
    - If d_mem_ready=0, hold strobes and latched values and stay in ISSUE. The watchdog does not count here.
  - WAIT:
    - Downstream strobes are low. The watchdog increments each cycle.
    - On d_mem_valid=1: capture d_mem_out_data into the owner's rdata register and go to DONE.
    - If watchdog reaches TIMEOUT_CYCLES without valid: set timeout_err, load rdata with all-zero, and go to DONE.
    - d_mem_valid in the same cycle as the timeout: the data wins, no error.
  - DONE:
    - Owner done=1 for one cycle. Update last_grant=owner, clear watchdog, return to IDLE.
    - Minimum issue-to-issue spacing is 3 cycles (IDLE→ISSUE→DONE for a write).
- Requesters must drop read/write in the cycle after done. A request still high in the IDLE cycle after DONE is treated as a new request.
- d_mem_valid outside WAIT is ignored.
- pN_rdata holds its last value until the next read completion on that port.
- p0_done and p1_done are never high together.
- timeout_err clears only on reset.
- Request inputs change while in ISSUE/WAIT: no effect; the latched values are used.

Test Plan:
- Single read, port 0: address 0x00010, d_mem_ready=1, valid with data 0xDEADBEEF 2 cycles after issue → one d_mem_read pulse at address 0x00010; p0_rdata=0xDEADBEEF with p0_done pulse; p1_done stays 0.
- Simultaneous requests after reset: p0 write 0x5 to 0x00020, p1 read 0x00030, both held → p0 served first; p1 issued 3 cycles later; grant_owner goes 0 then 1.
- Fairness: both ports hold requests continuously, responses immediate → grants alternate 0,1,0,1 over 4 transactions; no back-to-back grant to one port.
- Backpressure: d_mem_ready=0 for 5 cycles during a p1 write of 0xA5A5A5A5 → d_mem_write and address/data stable all 6 cycles; p1_done exactly 1 cycle after acceptance.
- Timeout: TIMEOUT_CYCLES=8, p0 read, never assert valid → p0_done after 8 WAIT cycles; p0_rdata=0; timeout_err=1 and sticky; next p1 request serviced normally.
- Async reset mid-WAIT: drop reset low for half a cycle during a p1 read → strobes, done and timeout_err go 0 immediately; a late d_mem_valid is ignored; next request is granted to port 0.
